gray_updown_counter: RTL

//  Parametrised up/down counter with registered binary and Gray-code outputs.

---
 rtl/gray_updown_counter.sv | 79 +++++++
 1 files changed

// File: rtl/gray_updown_counter.sv
// Up/down counter with registered binary and Gray-code outputs.
// The Gray output is taken directly from flops, so it is glitch-free and safe
// to hand to a pointer synchroniser in another clock domain.
module gray_updown_counter #(
  parameter int unsigned N         = 4,
  parameter bit          WRAP      = 1'b1,
  parameter bit          LOAD_GRAY = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         enable,
  input  logic         up_dn,
  output logic [N-1:0] bin_count,
  output logic [N-1:0] gray_count,
  output logic         tc
);

  logic [N-1:0] load_bin;
  logic [N-1:0] next_bin;
  logic [N-1:0] next_gray;
  logic         next_tc;
  logic         at_edge;

  // Convert the load value to binary when it arrives Gray-coded (MSB-first prefix XOR)
  always_comb begin
    load_bin = load_val;
    if (LOAD_GRAY) begin
      load_bin[N-1] = load_val[N-1];
      for (int unsigned i = 1; i < N; i++) begin
        load_bin[N-1-i] = load_bin[N-i] ^ load_val[N-1-i];
      end
    end
  end

  // Next binary count and terminal-count flag: clr > load > enable > hold
  always_comb begin
    next_bin = bin_count;
    next_tc  = 1'b0;
    at_edge  = up_dn ? (bin_count == '1) : (bin_count == '0);
    if (clr) begin
      next_bin = '0;
    end else if (load) begin
      next_bin = load_bin;
    end else if (enable) begin
      next_tc = at_edge;
      if (at_edge) begin
        if (WRAP) begin
          next_bin = up_dn ? '0 : '1;
        end
      end else if (up_dn) begin
        next_bin = bin_count + 1'b1;
      end else begin
        next_bin = bin_count - 1'b1;
      end
    end
  end

  // Gray code is derived from the next binary value so both registers move on the same edge
  always_comb begin
    next_gray = next_bin ^ (next_bin >> 1);
  end

  // Output registers with asynchronous active-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_count  <= '0;
      gray_count <= '0;
      tc         <= 1'b0;
    end else begin
      bin_count  <= next_bin;
      gray_count <= next_gray;
      tc         <= next_tc;
    end
  end

endmodule
